// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller with HI/LO registers, busy/stall handshake and a latency down-counter.
// Optional build macro MDU_DIV0_HOLD_EN: divide-by-zero leaves HI/LO unchanged instead of writing LO='1, HI=A.
module mdu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  mlu_op,
  input  logic        mlu_use,
  input  logic [2:0]  mlu_out,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] res,
  output logic        busy,
  output logic        stall
);

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;

  localparam logic [3:0] MUL_LAT = 4'd5;
  localparam logic [3:0] DIV_LAT = 4'd10;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic [63:0] mul_a, mul_b, mul_p;
  logic        div_sgn, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

  assign busy  = (cnt_q != '0);
  assign stall = busy & (start | mlu_use);

  always_comb begin
    case (mlu_out)
      3'd1:    res = hi_q;
      3'd2:    res = lo_q;
      default: res = '0;
    endcase
  end

  // Sign-extending to 64 bits makes the wrapped unsigned product equal the signed product.
  always_comb begin
    mul_a = {(op_q == 5'd1) ? {32{a_q[31]}} : 32'h0, a_q};
    mul_b = {(op_q == 5'd1) ? {32{b_q[31]}} : 32'h0, b_q};
    mul_p = mul_a * mul_b;
  end

  // Signed division on magnitudes avoids the MIN/-1 overflow trap; results negate back afterwards.
  always_comb begin
    div_sgn = (op_q == 5'd3);
    a_neg   = div_sgn & a_q[31];
    b_neg   = div_sgn & b_q[31];
    a_mag   = a_neg ? (~a_q + 32'd1) : a_q;
    b_mag   = b_neg ? (~b_q + 32'd1) : b_q;
    q_mag   = (b_mag == '0) ? '0 : a_mag / b_mag;
    r_mag   = (b_mag == '0) ? '0 : a_mag % b_mag;
    quo     = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem     = a_neg ? (~r_mag + 32'd1) : r_mag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (busy) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_d = ST_IDLE;
        if (state_q == ST_MUL) begin
          hi_d = mul_p[63:32];
          lo_d = mul_p[31:0];
        end else if (state_q == ST_DIV) begin
          if (b_q != '0) begin
            hi_d = rem;
            lo_d = quo;
          end else begin
`ifdef MDU_DIV0_HOLD_EN
            hi_d = hi_q;
            lo_d = lo_q;
`else
            hi_d = a_q;
            lo_d = '1;
`endif
          end
        end
      end
    end else if (start) begin
      case (mlu_op)
        5'd1, 5'd2: begin
          state_d = ST_MUL;
          cnt_d   = MUL_LAT;
          op_d    = mlu_op;
          a_d     = A;
          b_d     = B;
        end
        5'd3, 5'd4: begin
          state_d = ST_DIV;
          cnt_d   = DIV_LAT;
          op_d    = mlu_op;
          a_d     = A;
          b_d     = B;
        end
        5'd5:    hi_d = A;
        5'd6:    lo_d = A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: arithmetic reference model compared every cycle plus directed literal checks.
module tb_mdu_ctrl;
  logic        clk = 1'b0;
  logic        reset, start, mlu_use;
  logic [4:0]  mlu_op;
  logic [2:0]  mlu_out;
  logic [31:0] A, B, res;
  logic        busy, stall;

  int cmp_n = 0;
  int err_n = 0;

  mdu_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .mlu_op(mlu_op), .mlu_use(mlu_use),
    .mlu_out(mlu_out), .A(A), .B(B), .res(res), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the operands captured at accept.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_left;
  bit          m_commit;

  function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint x, y;
    x = sgn ? longint'($signed(a)) : longint'({32'h0, a});
    y = sgn ? longint'($signed(b)) : longint'({32'h0, b});
    return x * y;
  endfunction

  function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint x, y, q, r;
    x = sgn ? longint'($signed(a)) : longint'({32'h0, a});
    y = sgn ? longint'($signed(b)) : longint'({32'h0, b});
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] rd(input logic [2:0] s, input logic [31:0] h, input logic [31:0] l);
    return (s == 3'd1) ? h : ((s == 3'd2) ? l : 32'h0);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi <= '0; m_lo <= '0; p_hi <= '0; p_lo <= '0;
      m_left <= 0; m_commit <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1 && m_commit) begin
        m_hi <= p_hi;
        m_lo <= p_lo;
      end
    end else if (start) begin
      case (mlu_op)
        5'd1, 5'd2: begin
          {p_hi, p_lo} <= mul_ref(A, B, mlu_op == 5'd1);
          m_left <= 5; m_commit <= 1'b1;
        end
        5'd3, 5'd4: begin
          m_left <= 10;
          if (B == 32'h0) begin
`ifdef MDU_DIV0_HOLD_EN
            m_commit <= 1'b0;
`else
            m_commit <= 1'b1; p_lo <= '1; p_hi <= A;
`endif
          end else begin
            m_commit <= 1'b1;
            {p_hi, p_lo} <= div_ref(A, B, mlu_op == 5'd3);
          end
        end
        5'd5: m_hi <= A;
        5'd6: m_lo <= A;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("cyc_busy", {31'b0, busy}, {31'b0, m_left != 0});
    chk("cyc_stall", {31'b0, stall}, {31'b0, (m_left != 0) && (start || mlu_use)});
    chk("cyc_res", res, rd(mlu_out, m_hi, m_lo));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; mlu_op = op; A = a; B = b;
    step();
    start = 1'b0; mlu_op = 5'd0; A = $urandom; B = $urandom;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 30) begin
      step();
      n++;
    end
  endtask

  task automatic rd_chk(input string nm, input logic [2:0] sel, input logic [31:0] exp);
    mlu_out = sel;
    #1;
    chk(nm, res, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; mlu_use = 1'b0; mlu_op = 5'd0; mlu_out = 3'd0; A = '0; B = '0;
    #12;
    start = 1'b1; mlu_op = 5'd1; mlu_use = 1'b1;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    rd_chk("rst_hi", 3'd1, 32'h0);
    rd_chk("rst_lo", 3'd2, 32'h0);
    start = 1'b0; mlu_op = 5'd0; mlu_use = 1'b0;
    step();
    reset = 1'b0;
    step();

    issue(5'd1, 32'hFFFFFFFD, 32'd7);
    wait_idle(n);
    chk("mult_lat", n, 32'd5);
    rd_chk("mult_lo", 3'd2, 32'hFFFFFFEB);
    rd_chk("mult_hi", 3'd1, 32'hFFFFFFFF);

    issue(5'd4, 32'd100, 32'd7);
    wait_idle(n);
    chk("divu_lat", n, 32'd10);
    rd_chk("divu_lo", 3'd2, 32'd14);
    rd_chk("divu_hi", 3'd1, 32'd2);

    issue(5'd3, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    chk("div_lat", n, 32'd10);
    rd_chk("div_lo", 3'd2, 32'hFFFFFFFD);
    rd_chk("div_hi", 3'd1, 32'hFFFFFFFF);

    issue(5'd1, 32'd6, 32'd7);
    mlu_use = 1'b1;
    rd_chk("stall_old_lo", 3'd2, 32'hFFFFFFFD);
    n = 0;
    while (stall && n < 30) begin
      step();
      n++;
    end
    chk("stall_len", n, 32'd5);
    chk("stall_busy_end", {31'b0, busy}, 32'd0);
    rd_chk("stall_lo", 3'd2, 32'd42);
    mlu_use = 1'b0;

    start = 1'b1; mlu_op = 5'd1; A = 32'd3; B = 32'd5;
    step();
    mlu_op = 5'd4; A = 32'd50; B = 32'd8;
    #1;
    chk("b2b_stall", {31'b0, stall}, 32'd1);
    wait_idle(n);
    chk("b2b_first_lat", n, 32'd5);
    rd_chk("b2b_first_lo", 3'd2, 32'd15);
    step();
    start = 1'b0; mlu_op = 5'd0;
    chk("b2b_no_bubble", {31'b0, busy}, 32'd1);
    wait_idle(n);
    chk("b2b_second_lat", n, 32'd10);
    rd_chk("b2b_lo", 3'd2, 32'd6);
    rd_chk("b2b_hi", 3'd1, 32'd2);

    issue(5'd5, 32'h12345678, 32'h0);
    chk("mthi_busy", {31'b0, busy}, 32'd0);
    rd_chk("mthi_hi", 3'd1, 32'h12345678);
    rd_chk("mthi_lo", 3'd2, 32'd6);
    issue(5'd6, 32'hAAAA5555, 32'h0);
    rd_chk("mtlo_lo", 3'd2, 32'hAAAA5555);
    rd_chk("mtlo_hi", 3'd1, 32'h12345678);

    issue(5'd7, 32'hDEADBEEF, 32'd1);
    issue(5'd0, 32'hDEADBEEF, 32'd1);
    chk("inv_busy", {31'b0, busy}, 32'd0);
    rd_chk("inv_hi", 3'd1, 32'h12345678);
    rd_chk("inv_lo", 3'd2, 32'hAAAA5555);
    rd_chk("sel_zero", 3'd5, 32'h0);

    issue(5'd3, 32'd5, 32'd0);
    wait_idle(n);
    chk("div0_lat", n, 32'd10);
`ifdef MDU_DIV0_HOLD_EN
    rd_chk("div0_lo", 3'd2, 32'hAAAA5555);
    rd_chk("div0_hi", 3'd1, 32'h12345678);
`else
    rd_chk("div0_lo", 3'd2, 32'hFFFFFFFF);
    rd_chk("div0_hi", 3'd1, 32'd5);
`endif

    issue(5'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    rd_chk("ovf_lo", 3'd2, 32'h80000000);
    rd_chk("ovf_hi", 3'd1, 32'h0);

    issue(5'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle(n);
    rd_chk("multu_hi", 3'd1, 32'hFFFFFFFE);
    rd_chk("multu_lo", 3'd2, 32'h00000001);
    issue(5'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle(n);
    rd_chk("mults_hi", 3'd1, 32'h0);
    rd_chk("mults_lo", 3'd2, 32'h1);

    issue(5'd3, 32'd100, 32'd3);
    step(); step(); step();
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    rd_chk("abort_hi", 3'd1, 32'h0);
    rd_chk("abort_lo", 3'd2, 32'h0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("abort_busy_late", {31'b0, busy}, 32'd0);
    rd_chk("abort_lo_late", 3'd2, 32'h0);
    rd_chk("abort_hi_late", 3'd1, 32'h0);

    reset = 1'b1;
    step();
    reset = 1'b0;
    issue(5'd1, 32'd2, 32'd3);
    chk("first_accept", {31'b0, busy}, 32'd1);
    wait_idle(n);
    chk("first_lat", n, 32'd5);
    rd_chk("first_lo", 3'd2, 32'd6);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
